treasure_uart_rx: RTL and testbench

- Receives 8N1 serial frames at 9600 baud from the Arduino on a single RX line.
- Decodes tagged treasure bytes into color and shape codes, holds them stable, and flags framing, tag and stale-data conditions.
- Sits at the FPGA pin boundary and feeds the display and maze logic.
- Uses the same treasure encoding as the treasure generator: color 0x=none, 11=blue, 10=red; shape 00=none, 01=square, 10=triangle, 11=diamond.

---
 rtl/treasure_pkg.sv | 26 ++
 rtl/uart_rx_core.sv | 99 +++++++++
 rtl/treasure_uart_rx.sv | 65 ++++++
 tb/tb_treasure_uart_rx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/treasure_pkg.sv
// treasure_pkg: treasure encodings, link timing constants and receiver state encoding
// shared by the UART receiver and the rest of the treasure datapath.
package treasure_pkg;
  localparam int CLKS_PER_BIT = 5208;
  localparam int STALE_CLKS = 49996800;
  localparam logic [3:0] TAG = 4'hA;
  localparam int CNT_W = 13;
  localparam int IDX_W = 3;
  localparam int STALE_W = 26;
  localparam logic [1:0] COLOR_NONE = 2'b00;
  localparam logic [1:0] COLOR_RED = 2'b10;
  localparam logic [1:0] COLOR_BLUE = 2'b11;
  localparam logic [1:0] SHAPE_NONE = 2'b00;
  localparam logic [1:0] SHAPE_SQUARE = 2'b01;
  localparam logic [1:0] SHAPE_TRIANGLE = 2'b10;
  localparam logic [1:0] SHAPE_DIAMOND = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_e;
  typedef struct packed {
    logic [1:0] color;
    logic [1:0] shape;
  } treasure_t;
  localparam treasure_t TREASURE_NONE = '{color: COLOR_NONE, shape: SHAPE_NONE};
  function automatic treasure_t decode(input logic [7:0] b);
    return '{color: b[3:2], shape: b[1:0]};
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with input synchronizer, mid-bit sampling FSM and
// registered byte/frame-error outputs; done_o/data_o expose the stop-bit decision.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = treasure_pkg::CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       done_o,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  import treasure_pkg::*;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  rx_state_e state_q, state_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic fall, bit_tick;
  assign fall = rx_prev_q & ~rx_s2_q;
  assign bit_tick = cnt_q == BIT_LAST;
  assign data_o = shift_q;
  assign rx_byte_o = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o = ferr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      byte_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      byte_q <= byte_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    byte_d = byte_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        state_d = fall ? ST_START : ST_IDLE;
      end
      ST_START: if (cnt_q == HALF_LAST) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (bit_tick) begin
        cnt_d = '0;
        shift_d = {rx_s2_q, shift_q[7:1]};
        idx_d = idx_q + 1'b1;
        state_d = idx_q == 3'd7 ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (bit_tick) begin
        cnt_d = '0;
        done_o = rx_s2_q;
        valid_d = rx_s2_q;
        ferr_d = ~rx_s2_q;
        byte_d = rx_s2_q ? shift_q : byte_q;
        state_d = rx_s2_q ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        cnt_d = '0;
        state_d = rx_s2_q ? ST_IDLE : ST_BREAK;
      end
      default: begin
        cnt_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/treasure_uart_rx.sv
// treasure_uart_rx: serial treasure link receiver; decodes tagged bytes into held
// color/shape codes and clears them when no valid treasure arrives for STALE_CLKS.
module treasure_uart_rx #(
  parameter int         CLKS_PER_BIT = treasure_pkg::CLKS_PER_BIT,
  parameter logic [3:0] TAG          = treasure_pkg::TAG,
  parameter int         STALE_CLKS   = treasure_pkg::STALE_CLKS
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic [1:0] treasure_color_o,
  output logic [1:0] treasure_shape_o,
  output logic       treasure_valid_o,
  output logic       frame_err_o,
  output logic       tag_err_o,
  output logic       stale_o
);
  import treasure_pkg::*;
  localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CLKS);
  logic [7:0] data;
  logic done, upd, timeout;
  treasure_t hold_q, hold_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;
  logic stale_q, stale_d, tv_q, te_q;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .data_o      (data),
    .done_o      (done),
    .rx_byte_o   (rx_byte_o),
    .byte_valid_o(byte_valid_o),
    .frame_err_o (frame_err_o)
  );
  assign upd = done && data[7:4] == TAG;
  // a fresh treasure in the same cycle as the timeout keeps the data live
  always_comb begin
    stale_cnt_d = upd ? '0 : stale_cnt_q == STALE_LAST ? stale_cnt_q : stale_cnt_q + 1'b1;
    timeout = stale_cnt_d == STALE_LAST;
    hold_d = upd ? decode(data) : timeout ? TREASURE_NONE : hold_q;
    stale_d = upd ? 1'b0 : timeout | stale_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= TREASURE_NONE;
      stale_cnt_q <= '0;
      stale_q <= 1'b0;
      tv_q <= 1'b0;
      te_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q <= stale_d;
      tv_q <= upd;
      te_q <= done & ~upd;
    end
  end
  assign treasure_color_o = hold_q.color;
  assign treasure_shape_o = hold_q.shape;
  assign treasure_valid_o = tv_q;
  assign tag_err_o = te_q;
  assign stale_o = stale_q;
endmodule

// File: tb/tb_treasure_uart_rx.sv
// tb_treasure_uart_rx: directed and random 8N1 frames against a frame-level model of
// byte/treasure/error events and the stale timeout.
module tb_treasure_uart_rx;
  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  localparam int STALE = 3000;
  localparam int LAT = HALF + 9 * CPB + 3;
  localparam logic [3:0] TAG = 4'hA;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [7:0] rx_byte;
  logic [1:0] color, shape;
  logic bv, tv, fe, te, stale;
  int checks = 0, failures = 0;
  int n_bv = 0, n_tv = 0, n_fe = 0, n_te = 0, n_both = 0;
  int exp_bv = 0, exp_tv = 0, exp_fe = 0, exp_te = 0;
  int unsigned cyc = 0, bv_cyc = 0, last_upd = 0;
  logic [7:0] exp_byte = '0;
  logic [1:0] m_color = '0, m_shape = '0;
  treasure_uart_rx #(.CLKS_PER_BIT(CPB), .STALE_CLKS(STALE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .rx_byte_o(rx_byte), .byte_valid_o(bv),
    .treasure_color_o(color), .treasure_shape_o(shape), .treasure_valid_o(tv),
    .frame_err_o(fe), .tag_err_o(te), .stale_o(stale)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bv) begin n_bv <= n_bv + 1; bv_cyc <= cyc; end
    if (tv) n_tv <= n_tv + 1;
    if (fe) n_fe <= n_fe + 1;
    if (te) n_te <= n_te + 1;
    if (bv && tv) n_both <= n_both + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic st;
    st = (cyc - last_upd) >= STALE;
    chk({tag, ".bv_cnt"}, n_bv, exp_bv);
    chk({tag, ".tv_cnt"}, n_tv, exp_tv);
    chk({tag, ".fe_cnt"}, n_fe, exp_fe);
    chk({tag, ".te_cnt"}, n_te, exp_te);
    chk({tag, ".bv_tv_together"}, n_both, exp_tv);
    chk({tag, ".byte"}, rx_byte, exp_byte);
    chk({tag, ".stale"}, stale, st);
    chk({tag, ".color"}, color, st ? 2'b00 : m_color);
    chk({tag, ".shape"}, shape, st ? 2'b00 : m_shape);
  endtask
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_ok);
    int unsigned n0;
    n0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (stop_ok) begin
      exp_bv++;
      exp_byte = b;
      if (b[7:4] == TAG) begin
        exp_tv++;
        m_color = b[3:2];
        m_shape = b[1:0];
        last_upd = n0 + LAT;
      end else exp_te++;
      chk({tag, ".latency"}, bv_cyc - n0, LAT);
    end else exp_fe++;
    check_all(tag);
  endtask
  initial begin
    logic [7:0] b;
    logic ok;
    repeat (3) @(negedge clk);
    chk("rst.byte", rx_byte, 8'h00);
    chk("rst.pulses", {bv, tv, fe, te}, 4'b0000);
    chk("rst.treasure", {color, shape}, 4'b0000);
    chk("rst.stale", stale, 1'b0);
    rst_n = 1'b1;
    last_upd = cyc;
    repeat (CPB) @(negedge clk);
    send_frame("ae", 8'hAE, 1'b1);
    chk("ae.blue_triangle", {color, shape}, 4'b1110);
    send_frame("a9", 8'hA9, 1'b1);
    chk("a9.red_square", {color, shape}, 4'b1001);
    send_frame("57", 8'h57, 1'b1);
    chk("57.unchanged", {color, shape}, 4'b1001);
    send_frame("af_bad", 8'hAF, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    check_all("break_low");
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_all("break_end");
    rx = 1'b0;
    repeat ($urandom_range(1, HALF - 2)) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_all("glitch");
    send_frame("ad", 8'hAD, 1'b1);
    chk("ad.blue_square", {color, shape}, 4'b1101);
    send_frame("ab", 8'hAB, 1'b1);
    while (cyc < last_upd + STALE - 1) @(negedge clk);
    check_all("pre_stale");
    chk("pre_stale.level", stale, 1'b0);
    @(negedge clk);
    check_all("stale");
    chk("stale.level", {stale, color, shape}, 5'b10000);
    send_frame("a6", 8'hA6, 1'b1);
    chk("a6.fresh", {stale, color, shape}, 5'b00110);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    exp_byte = '0;
    m_color = '0;
    m_shape = '0;
    repeat (2) @(negedge clk);
    chk("midrst.outputs", {rx_byte, color, shape, stale}, 13'h0);
    rx = 1'b1;
    rst_n = 1'b1;
    last_upd = cyc;
    repeat (2 * CPB) @(negedge clk);
    check_all("midrst.after");
    send_frame("ac", 8'hAC, 1'b1);
    chk("ac.blue_none", {color, shape}, 4'b1100);
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) b[7:4] = TAG;
      ok = $urandom_range(0, 5) != 0;
      send_frame($sformatf("rnd%0d", i), b, ok);
      if (!ok) begin
        repeat ($urandom_range(0, 3) * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check_all($sformatf("rnd%0d.recover", i));
      end
      repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
